// File: rtl/mem_pkg.sv
// Shared encodings and record types for the MEM pipeline stage and its
// data-memory bus sequencer.
package mem_pkg;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_MEM  = 2'b01,
        MTR_LINK = 2'b10,
        MTR_RSVD = 2'b11    // decodes like MTR_ALU
    } mtr_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    // Contents of the MEM/WB pipeline register.
    typedef struct packed {
        logic        reg_wr;
        logic [4:0]  reg_dst;
        logic [31:0] data;
    } mem_wb_t;

    // Instruction fields held while a bus transaction is outstanding.
    typedef struct packed {
        logic        reg_wr;
        logic [4:0]  reg_dst;
        mtr_e        mtr;
        logic [31:0] alu;
        logic [31:0] pc;
    } mem_instr_t;

    localparam mem_wb_t    WB_BUBBLE    = '0;
    localparam mem_instr_t INSTR_BUBBLE = '0;

    function automatic logic [31:0] wb_select(
        input mtr_e        mtr,
        input logic [31:0] alu,
        input logic [31:0] ld,
        input logic [31:0] pc
    );
        case (mtr)
            MTR_MEM:  return ld;
            MTR_LINK: return pc + 32'd4;
            default:  return alu;
        endcase
    endfunction

    function automatic mem_wb_t make_wb(
        input logic        reg_wr,
        input logic [4:0]  reg_dst,
        input logic [31:0] data
    );
        mem_wb_t wb;
        wb.reg_wr  = reg_wr && (reg_dst != 5'd0);  // r0 is hardwired to zero
        wb.reg_dst = reg_dst;
        wb.data    = data;
        return wb;
    endfunction

endpackage

// File: rtl/dmem_bus_fsm.sv
// Request/ack sequencer for the data-memory bus: IDLE/BUSY state, timeout
// counter, registered bus drive, and the stall/done/abort strobes.
module dmem_bus_fsm
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        mem_op,
    input  logic        aligned,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        idle,
    output logic        accept,
    output logic        misalign,
    output logic        done,
    output logic        abort,
    output logic        mem_stall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    always_comb begin
        idle     = (state_q == ST_IDLE);
        accept   = idle && !flush && mem_op && aligned;
        misalign = idle && !flush && mem_op && !aligned;
        done     = !idle && dmem_ack;
        abort    = !idle && !dmem_ack && (cnt_q == CNT_LAST);
        // Completion and abort both release upstream in the same cycle.
        mem_stall = !reset && (accept || (!idle && !dmem_ack && !abort));

        // NOTE: every _d takes its hold value before the branches, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (accept) begin
            state_d = ST_BUSY;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = addr;
            wdata_d = wdata;
        end else if (done || abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            req_d   = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end else if (!idle) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues word loads/stores on the data bus, stalls
// upstream while busy, flags faults, and owns the MEM/WB register.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        RegWr_i,
    input  logic        MemRead_i,
    input  logic        MemWr_i,
    input  logic [1:0]  MemtoReg_i,
    input  logic [31:0] ALUOut_i,
    input  logic [31:0] MemWrData_i,
    input  logic [4:0]  RegDstAddr_i,
    input  logic [31:0] PC_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        exc_misaligned,
    output logic        bus_err,
    output logic [31:0] exc_addr,
    output logic        wb_RegWr,
    output logic [4:0]  wb_RegDst,
    output logic [31:0] wb_Data
);

    logic mem_op, aligned, is_store;
    logic idle, accept, misalign, done, abort;

    mem_instr_t  lat_q, lat_d;
    mem_wb_t     wb_q, wb_d;
    logic        exc_mis_q, exc_mis_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    // A combined read+write request is executed as a load.
    assign mem_op   = MemRead_i || MemWr_i;
    assign aligned  = (ALUOut_i[1:0] == 2'b00);
    assign is_store = MemWr_i && !MemRead_i;

    dmem_bus_fsm #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_bus (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .mem_op     (mem_op),
        .aligned    (aligned),
        .is_store   (is_store),
        .addr       (ALUOut_i),
        .wdata      (MemWrData_i),
        .dmem_ack   (dmem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .idle       (idle),
        .accept     (accept),
        .misalign   (misalign),
        .done       (done),
        .abort      (abort),
        .mem_stall  (mem_stall)
    );

    always_comb begin
        lat_d = lat_q;
        if (accept) begin
            lat_d = '{reg_wr:  RegWr_i,
                      reg_dst: RegDstAddr_i,
                      mtr:     mtr_e'(MemtoReg_i),
                      alu:     ALUOut_i,
                      pc:      PC_i};
        end

        // Anything other than a completed access or a plain ALU op writes a bubble.
        wb_d = WB_BUBBLE;
        if (done) begin
            wb_d = make_wb(lat_q.reg_wr, lat_q.reg_dst,
                           wb_select(lat_q.mtr, lat_q.alu, dmem_rdata, lat_q.pc));
        end else if (idle && !flush && !mem_op) begin
            wb_d = make_wb(RegWr_i, RegDstAddr_i,
                           wb_select(mtr_e'(MemtoReg_i), ALUOut_i, 32'd0, PC_i));
        end

        exc_mis_d  = misalign;
        bus_err_d  = abort;
        exc_addr_d = exc_addr_q;
        if (misalign) begin
            exc_addr_d = ALUOut_i;
        end else if (abort) begin
            exc_addr_d = dmem_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_q      <= INSTR_BUBBLE;
            wb_q       <= WB_BUBBLE;
            exc_mis_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            exc_addr_q <= '0;
        end else begin
            lat_q      <= lat_d;
            wb_q       <= wb_d;
            exc_mis_q  <= exc_mis_d;
            bus_err_q  <= bus_err_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    assign exc_misaligned = exc_mis_q;
    assign bus_err        = bus_err_q;
    assign exc_addr       = exc_addr_q;
    assign wb_RegWr       = wb_q.reg_wr;
    assign wb_RegDst      = wb_q.reg_dst;
    assign wb_Data        = wb_q.data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of instructions with a
// writeback scoreboard, plus hand sequences for faults and reset.
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    logic        clk, reset, flush;
    logic        RegWr_i, MemRead_i, MemWr_i;
    logic [1:0]  MemtoReg_i;
    logic [31:0] ALUOut_i, MemWrData_i, PC_i;
    logic [4:0]  RegDstAddr_i;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall, exc_misaligned, bus_err;
    logic [31:0] exc_addr;
    logic        wb_RegWr;
    logic [4:0]  wb_RegDst;
    logic [31:0] wb_Data;

    typedef struct packed {
        logic        reg_wr;
        logic [4:0]  dst;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct {
        string       name;
        logic        regwr, mrd, mwr;
        logic [1:0]  mtr;
        logic [31:0] alu, wdata, pc, rdata;
        logic [4:0]  dst;
        int          ack_cyc;   // BUSY cycle (1-based) carrying ack, 0 = never
        int          fl;        // 0 none, 1 flush in IDLE, 2 flush during BUSY
        int          exp_cyc;   // expected req-high cycles == stall-high cycles
        logic        exp_we;
        wb_exp_t     exp_wb;
        logic        exp_berr;
    } vec_t;

    vec_t    vecs[$];
    wb_exp_t sb_q[$];
    int      total = 0;
    int      bad   = 0;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .RegWr_i        (RegWr_i),
        .MemRead_i      (MemRead_i),
        .MemWr_i        (MemWr_i),
        .MemtoReg_i     (MemtoReg_i),
        .ALUOut_i       (ALUOut_i),
        .MemWrData_i    (MemWrData_i),
        .RegDstAddr_i   (RegDstAddr_i),
        .PC_i           (PC_i),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .mem_stall      (mem_stall),
        .exc_misaligned (exc_misaligned),
        .bus_err        (bus_err),
        .exc_addr       (exc_addr),
        .wb_RegWr       (wb_RegWr),
        .wb_RegDst      (wb_RegDst),
        .wb_Data        (wb_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        flush        = 1'b0;
        RegWr_i      = 1'b0;
        MemRead_i    = 1'b0;
        MemWr_i      = 1'b0;
        MemtoReg_i   = 2'b00;
        ALUOut_i     = 32'h0;
        MemWrData_i  = 32'h0;
        RegDstAddr_i = 5'd0;
        PC_i         = 32'h0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'h0;
    endtask

    function automatic vec_t mk(
        input string name, input logic regwr, input logic mrd, input logic mwr,
        input logic [1:0] mtr, input logic [31:0] alu, input logic [31:0] wdata,
        input logic [31:0] pc, input logic [4:0] dst, input int ack_cyc,
        input logic [31:0] rdata, input int fl, input int exp_cyc, input logic exp_we,
        input logic e_wr, input logic [4:0] e_dst, input logic [31:0] e_data,
        input logic e_berr);
        vec_t v;
        v.name = name; v.regwr = regwr; v.mrd = mrd; v.mwr = mwr; v.mtr = mtr;
        v.alu = alu; v.wdata = wdata; v.pc = pc; v.dst = dst; v.ack_cyc = ack_cyc;
        v.rdata = rdata; v.fl = fl; v.exp_cyc = exp_cyc; v.exp_we = exp_we;
        v.exp_wb.reg_wr = e_wr; v.exp_wb.dst = e_dst; v.exp_wb.data = e_data;
        v.exp_berr = e_berr;
        return v;
    endfunction

    // Presents one instruction, plays the bus slave, then scores writeback.
    task automatic run_vec(input vec_t v);
        int      n_req;
        int      n_stall;
        bit      finished;
        wb_exp_t exp;
        n_req    = 0;
        n_stall  = 0;
        finished = 1'b0;
        flush        = (v.fl == 1);
        RegWr_i      = v.regwr;
        MemRead_i    = v.mrd;
        MemWr_i      = v.mwr;
        MemtoReg_i   = v.mtr;
        ALUOut_i     = v.alu;
        MemWrData_i  = v.wdata;
        RegDstAddr_i = v.dst;
        PC_i         = v.pc;
        sb_q.push_back(v.exp_wb);
        for (int c = 0; c < 40 && !finished; c++) begin
            if (c > 0) flush = (v.fl == 2);
            dmem_ack   = (v.ack_cyc != 0) && (c == v.ack_cyc);
            dmem_rdata = dmem_ack ? v.rdata : 32'h0BAD_0BAD;
            #1;
            if (dmem_req) begin
                n_req++;
                check({v.name, ".addr"}, dmem_addr, v.alu);
                check({v.name, ".we"}, 32'(dmem_we), 32'(v.exp_we));
                if (v.exp_we) check({v.name, ".wdata"}, dmem_wdata, v.wdata);
            end
            if (mem_stall) n_stall++;
            else finished = 1'b1;
            step();
        end
        drive_nop();
        check({v.name, ".completed"}, 32'(finished), 32'd1);
        check({v.name, ".req_cycles"}, 32'(n_req), 32'(v.exp_cyc));
        check({v.name, ".stall_cycles"}, 32'(n_stall), 32'(v.exp_cyc));
        if (sb_q.size() == 0) begin
            check({v.name, ".sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check({v.name, ".wb_RegWr"}, 32'(wb_RegWr), 32'(exp.reg_wr));
            check({v.name, ".wb_RegDst"}, 32'(wb_RegDst), 32'(exp.dst));
            check({v.name, ".wb_Data"}, wb_Data, exp.data);
        end
        check({v.name, ".bus_err"}, 32'(bus_err), 32'(v.exp_berr));
        if (v.exp_berr) check({v.name, ".exc_addr"}, exc_addr, v.alu);
        check({v.name, ".req_after"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        //          name          wr mr mw mtr    alu           wdata         pc            dst  ack rdata         fl cyc we  e_wr e_dst e_data        berr
        vecs.push_back(mk("alu",       1, 0, 0, 2'b00, 32'h0000_1234, 32'h0,         32'h0000_0040, 5,  0, 32'h0,         0, 0, 0, 1, 5,  32'h0000_1234, 0));
        vecs.push_back(mk("flush_idle",1, 0, 0, 2'b00, 32'h0000_0099, 32'h0,         32'h0000_0044, 8,  0, 32'h0,         1, 0, 0, 0, 0,  32'h0,         0));
        vecs.push_back(mk("load",      1, 1, 0, 2'b01, 32'h0000_0100, 32'h0,         32'h0000_0048, 7,  3, 32'hDEAD_BEEF, 0, 3, 0, 1, 7,  32'hDEAD_BEEF, 0));
        vecs.push_back(mk("store",     0, 0, 1, 2'b00, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0000_004C, 0,  1, 32'h0,         0, 1, 1, 0, 0,  32'h0000_0200, 0));
        vecs.push_back(mk("jal",       1, 0, 0, 2'b10, 32'h0,         32'h0,         32'h0000_0400, 31, 0, 32'h0,         0, 0, 0, 1, 31, 32'h0000_0404, 0));
        vecs.push_back(mk("dst_r0",    1, 0, 0, 2'b00, 32'h0000_0055, 32'h0,         32'h0000_0050, 0,  0, 32'h0,         0, 0, 0, 0, 0,  32'h0000_0055, 0));
        vecs.push_back(mk("mtr_rsvd",  1, 0, 0, 2'b11, 32'h0000_0077, 32'h0,         32'h0000_0900, 3,  0, 32'h0,         0, 0, 0, 1, 3,  32'h0000_0077, 0));
        vecs.push_back(mk("link_wrap", 1, 0, 0, 2'b10, 32'h0000_0010, 32'h0,         32'hFFFF_FFFC, 1,  0, 32'h0,         0, 0, 0, 1, 1,  32'h0,         0));
        vecs.push_back(mk("rd_wr_busyflush",1,1,1,2'b01,32'h0000_0300,32'h1234_5678, 32'h0000_0054, 9,  2, 32'h1122_3344, 2, 2, 0, 1, 9,  32'h1122_3344, 0));
        vecs.push_back(mk("ack_last",  1, 1, 0, 2'b01, 32'h0000_02F0, 32'h0,         32'h0000_0058, 11, 4, 32'h600D_F00D, 0, 4, 0, 1, 11, 32'h600D_F00D, 0));
        vecs.push_back(mk("timeout",   1, 1, 0, 2'b01, 32'h0000_0240, 32'h0,         32'h0000_005C, 6,  0, 32'h0,         0, 4, 0, 0, 0,  32'h0,         1));

        reset = 1'b1;
        drive_nop();
        #12;
        check("rst.dmem_req", 32'(dmem_req), 32'd0);
        check("rst.mem_stall", 32'(mem_stall), 32'd0);
        check("rst.wb_RegWr", 32'(wb_RegWr), 32'd0);
        check("rst.wb_Data", wb_Data, 32'd0);
        check("rst.exc_addr", exc_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stray ack in IDLE right after the timeout abort.
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        #1;
        check("stray.mem_stall", 32'(mem_stall), 32'd0);
        step();
        dmem_ack = 1'b0;
        check("stray.dmem_req", 32'(dmem_req), 32'd0);
        check("stray.wb_RegWr", 32'(wb_RegWr), 32'd0);
        check("stray.wb_Data", wb_Data, 32'd0);
        check("stray.bus_err_pulse", 32'(bus_err), 32'd0);

        // Misaligned load: no request, one-cycle fault pulse, address held.
        RegWr_i = 1'b1; MemRead_i = 1'b1; MemtoReg_i = 2'b01;
        ALUOut_i = 32'h0000_0103; RegDstAddr_i = 5'd4;
        #1;
        check("mis.mem_stall", 32'(mem_stall), 32'd0);
        step();
        check("mis.exc_misaligned", 32'(exc_misaligned), 32'd1);
        check("mis.exc_addr", exc_addr, 32'h0000_0103);
        check("mis.wb_RegWr", 32'(wb_RegWr), 32'd0);
        check("mis.dmem_req", 32'(dmem_req), 32'd0);
        drive_nop();
        step();
        check("mis.pulse_end", 32'(exc_misaligned), 32'd0);
        check("mis.exc_addr_held", exc_addr, 32'h0000_0103);

        // Reset asserted in the middle of a BUSY transaction.
        RegWr_i = 1'b1; MemRead_i = 1'b1; MemtoReg_i = 2'b01;
        ALUOut_i = 32'h0000_0180; RegDstAddr_i = 5'd2;
        step();
        check("rstbusy.req_before", 32'(dmem_req), 32'd1);
        check("rstbusy.stall_before", 32'(mem_stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstbusy.dmem_req", 32'(dmem_req), 32'd0);
        check("rstbusy.mem_stall", 32'(mem_stall), 32'd0);
        check("rstbusy.wb_RegWr", 32'(wb_RegWr), 32'd0);
        check("rstbusy.wb_RegDst", 32'(wb_RegDst), 32'd0);
        check("rstbusy.wb_Data", wb_Data, 32'd0);
        check("rstbusy.exc_addr", exc_addr, 32'd0);
        drive_nop();
        @(negedge clk);
        reset = 1'b0;
        step();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        step();
        dmem_ack = 1'b0;
        check("rstbusy.late_ack_wr", 32'(wb_RegWr), 32'd0);
        check("rstbusy.late_ack_req", 32'(dmem_req), 32'd0);

        run_vec(mk("post_rst", 1, 0, 0, 2'b00, 32'h0000_0ABC, 32'h0, 32'h0000_0060, 12, 0,
                   32'h0, 0, 0, 0, 1, 12, 32'h0000_0ABC, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the 5-stage pipeline. Consumes the EX/MEM register outputs and performs word loads/stores on a variable-latency request/ack data-memory bus. Stalls upstream while a transaction is outstanding and owns the MEM/WB pipeline register feeding writeback. Handles misalignment and bus timeout.

Parameters:
TIMEOUT, 16, max BUSY cycles waiting for dmem_ack before abort (≥1)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
flush  in  1  sync; drop instruction presented in IDLE
RegWr_i  in  1  EX/MEM reg-write enable
MemRead_i  in  1  load
MemWr_i  in  1  store
MemtoReg_i  in  2  WB source: 00 ALU, 01 load data, 10 link (PC+4), 11 reserved→ALU
ALUOut_i  in  32  ALU result / effective address
MemWrData_i  in  32  store data
RegDstAddr_i  in  5  destination register
PC_i  in  32  instruction PC
dmem_req  out  1  bus request (registered)
dmem_we  out  1  1=write
dmem_addr  out  32  word address (bits[1:0]=0)
dmem_wdata  out  32  store data
dmem_rdata  in  32  load data, valid with ack
dmem_ack  in  1  1-cycle completion
mem_stall  out  1  freeze PC/IF/ID/EX and EX/MEM
exc_misaligned  out  1  1-cycle pulse
bus_err  out  1  1-cycle pulse on timeout
exc_addr  out  32  faulting address, held until next fault
wb_RegWr  out  1  MEM/WB reg-write
wb_RegDst  out  5  MEM/WB destination
wb_Data  out  32  MEM/WB writeback value

Behaviour:
- Reset (async): state IDLE, counter 0; all outputs 0; a dmem_req in flight is dropped immediately, no completion reported.
- mem_op = MemRead_i | MemWr_i; aligned = ALUOut_i[1:0]==0. MemRead_i & MemWr_i both 1: treated as load.
- FSM IDLE/BUSY.
- IDLE, flush=1: MEM/WB ← bubble (wb_RegWr=0, wb_RegDst=0, wb_Data=0); no request; mem_stall=0.
- IDLE, no mem_op: MEM/WB ← instruction next edge (1-cycle latency); mem_stall=0.
- IDLE, mem_op & !aligned: no request; exc_misaligned=1 next cycle; exc_addr ← ALUOut_i; MEM/WB ← bubble; mem_stall=0.
- IDLE, mem_op & aligned: latch RegWr, RegDst, MemtoReg, ALUOut, PC, store data; state→BUSY; dmem_req/we/addr/wdata driven from next cycle; mem_stall=1 (comb); MEM/WB ← bubble.
- BUSY: dmem_req held with stable addr/we/wdata until ack or timeout; flush ignored (committed op completes).
- BUSY & dmem_ack: dmem_req→0 next edge; MEM/WB ← latched instruction (load data captured from dmem_rdata); state→IDLE; mem_stall=0 this cycle, so upstream advances on the same edge. Minimum load/store latency: 2 cycles.
- BUSY & !ack: counter++; mem_stall=1; MEM/WB ← bubble. When counter==TIMEOUT-1 and no ack: abort, dmem_req→0, bus_err=1 next cycle, exc_addr ← address, MEM/WB ← bubble, IDLE, mem_stall=0 this cycle.
- dmem_ack seen in IDLE (late/stray): ignored.
- wb_Data: MemtoReg 00/11 → ALUOut; 01 → load data; 10 → PC+4 (mod 2^32).
- wb_RegWr forced 0 when RegDst==0.
- Stores: wb_RegWr = latched RegWr (normally 0).

Decomposition:
- mem_pkg: MemtoReg encodings (MTR_ALU, MTR_MEM, MTR_LINK), FSM state encodings, bubble constants.
- One sub-module, dmem_bus_fsm: IDLE/BUSY, timeout counter, dmem_* drive, stall/abort/done.
- MEM/WB register and writeback mux stay in the top module.

Test Plan:
- Non-mem ALU op, RegWr=1, Dst=5, ALUOut=0x1234 → next cycle wb_RegWr=1, wb_RegDst=5, wb_Data=0x1234; mem_stall never 1.
- Load addr 0x100, ack after 3 BUSY cycles with rdata 0xDEADBEEF → dmem_req high 3 cycles with addr 0x100, we=0; mem_stall high 3 cycles; next cycle wb_Data=0xDEADBEEF.
- Store addr 0x200, data 0xA5A5A5A5, ack in first BUSY cycle → 1-cycle req with we=1, wdata=0xA5A5A5A5; wb_RegWr=0; total 2 cycles.
- Load addr 0x103 → no dmem_req; exc_misaligned 1-cycle pulse; exc_addr=0x103; wb_RegWr=0; no stall.
- Load, TIMEOUT=4, no ack → req high 4 cycles, then drops; bus_err pulse; exc_addr=address; later stray ack ignored.
- Reset mid-BUSY → dmem_req, mem_stall, wb_* immediately 0. jal (MemtoReg=10, PC=0x400, Dst=31) → wb_Data=0x404. Write to Dst=0 → wb_RegWr=0.
